piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
//
// PURPOSE
// - Parametrised parallel-in serial-out shifter with a load handshake, stall control and completion flag.
// - Accepts one WIDTH-bit word, then emits it one bit per enabled clock, LSB-first or MSB-first.
// - Used as the operand serializer in front of the serial adder and other bit-serial datapaths.
//
// PARAMETERS
// - WIDTH      8  data word width, legal range 2..32
// - MSB_FIRST  0  0 = bit[0] first; 1 = bit[WIDTH-1] first
//
// PORTS
// - clk         in   1      clock, rising edge
// - rst         in   1      reset, asynchronous, active-high
// - load_valid  in   1      load_data is valid
// - load_ready  out  1      block can accept a word (state IDLE)
// - load_data   in   WIDTH  parallel word
// - shift_en    in   1      advance one bit this cycle; 0 = stall
// - ser_out     out  1      current serial bit, registered
// - ser_valid   out  1      ser_out holds a bit of the active word
// - busy        out  1      word in flight (state != IDLE)
// - done        out  1      one-cycle pulse after the final bit is consumed
//
// BEHAVIOUR
// - Reset (async): state=IDLE, shift reg=0, bit counter=0.
//   Outputs: ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1.
// - States:
//   - IDLE -> SHIFT on load_valid&&load_ready.
//   - SHIFT -> IDLE when the last bit is consumed (shift_en=1 while counter=WIDTH-1, or PAR_BIT stage with parity).
// - Load: accepted at edge N. From cycle N+1: ser_valid=1, busy=1, ser_out = first bit per MSB_FIRST.
// - Bit consumed at each edge with shift_en=1 and ser_valid=1. Next bit appears on ser_out the following cycle.
// - shift_en=0 in SHIFT: ser_out, counter and shift reg hold (stall, any length).
// - shift_en ignored in IDLE. load_valid ignored while load_ready=0; no queueing, word dropped upstream responsibility.
// - load_ready is combinational: (state==IDLE).
// - Final-bit edge: next cycle ser_valid=0, busy=0, done=1 (exactly one cycle), load_ready=1, ser_out=0.
// - Back-to-back: a load in the cycle done=1 is accepted; its first bit appears next cycle.
//   Minimum word period is WIDTH+1 cycles (WIDTH+2 with parity).
// - Counter width: $clog2(WIDTH+1). Counts consumed bits 0..WIDTH-1. No wrap beyond WIDTH.
// - Reset asserted mid-word aborts immediately: word discarded, done not pulsed.
// - All state in one clocked process. Blocking assignments not used in clocked logic.
//
// CONFIGURATION
// - Macro PISO_PARITY_EN.
//   - Defined: after the WIDTH data bits, one extra bit = even parity (XOR of load_data, captured at load).
//     ser_valid stays 1 for it, consumed with shift_en like data. done pulses after the parity bit.
//   - Undefined: no parity stage, no parity register. Word is exactly WIDTH bits.
//
// TESTING
// - Reset: assert rst mid-cycle, no clock -> all outputs at reset values, load_ready=1.
// - WIDTH=8, MSB_FIRST=0, load 0xA5, shift_en=1 -> ser_out 1,0,1,0,0,1,0,1 on cycles N+1..N+8, done at N+9.
// - Same with MSB_FIRST=1, load 0xA5 -> ser_out 1,0,1,0,0,1,0,1 reversed order check (bits 7..0). Load 0x80 -> 1 then 0x7.
// - Stall: load 0x0F, drop shift_en for 3 cycles after bit 2 -> ser_out holds bit 2. Sequence intact, done 3 cycles later.
// - Parity (PISO_PARITY_EN): load 0x07 -> 8 data bits then parity bit 1, done after 9th bit. Load 0x03 -> parity 0.
// - Reset at bit 4 of 0xFF -> ser_valid=0, busy=0, no done. Next load 0x01 serializes correctly.
//   Also: a load in the done cycle is accepted.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with load handshake, stall and done pulse
// Build option: define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ser_out;
  logic              r_done;
`ifdef PISO_PARITY_EN
  logic              r_par;
`endif

  logic              w_first_bit;
  logic [WIDTH-1:0]  w_shift_adv;
  logic              w_next_bit;
  logic              w_last;

  // The bit presented after a load and after each advance sits at the outgoing end of the register.
  assign w_first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign w_shift_adv = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  assign w_next_bit  = MSB_FIRST ? w_shift_adv[WIDTH-1] : w_shift_adv[0];
  assign w_last      = (r_cnt == LAST_CNT);

  // All sequential state: FSM register, shift register, bit counter, serial output and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ser_out <= 1'b0;
      r_done    <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_valid) begin
            r_shift   <= load_data;
            r_cnt     <= '0;
            r_ser_out <= w_first_bit;
`ifdef PISO_PARITY_EN
            r_par     <= ^load_data;
`endif
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_shift <= '0;
`ifdef PISO_PARITY_EN
              r_ser_out <= r_par;
`else
              r_ser_out <= 1'b0;
              r_done    <= 1'b1;
`endif
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              r_shift   <= w_shift_adv;
              r_ser_out <= w_next_bit;
            end
          end
        end
`ifdef PISO_PARITY_EN
        ST_PAR: begin
          if (shift_en) begin
            r_ser_out <= 1'b0;
            r_done    <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Next-state: a load starts a word; the final consumed bit (data or parity) returns to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_valid) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_en && w_last) begin
`ifdef PISO_PARITY_EN
          w_state_next = ST_PAR;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        if (shift_en) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake and status decode from state, serial bit and done come straight from flops.
  always_comb begin
    load_ready = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    ser_valid  = (r_state != ST_IDLE);
    ser_out    = r_ser_out;
    done       = r_done;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, LSB-first and MSB-first instances
`timescale 1ns/1ps
module tb_piso_serializer;

  localparam int DONE_TOK = 2;
`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;
  logic [1:0] w_load_ready;
  logic [1:0] w_ser_out;
  logic [1:0] w_ser_valid;
  logic [1:0] w_busy;
  logic [1:0] w_done;

  int n_chk;
  int n_fail;

  int q0[$];
  int q1[$];

  logic [7:0] v_data[8];
  logic [7:0] v_lsb[8];
  logic [7:0] v_msb[8];
  logic       v_par[8];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (w_load_ready[0]),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_out    (w_ser_out[0]),
    .ser_valid  (w_ser_valid[0]),
    .busy       (w_busy[0]),
    .done       (w_done[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (w_load_ready[1]),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_out    (w_ser_out[1]),
    .ser_valid  (w_ser_valid[1]),
    .busy       (w_busy[1]),
    .done       (w_done[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL ch%0d %s: got %0h expected %0h at %0t", ch, nm, act, exp, $time);
    end
  endtask

  function automatic int qsz(input int ch);
    return (ch == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int ch);
    return (ch == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int ch);
    if (ch == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endtask

  // Expected serial stream per word: emission-order literal (leftmost first), parity, then done token.
  task automatic push_word(input int idx);
    for (int k = 0; k < 8; k++) begin
      q0.push_back(int'(v_lsb[idx][7-k]));
      q1.push_back(int'(v_msb[idx][7-k]));
    end
`ifdef PISO_PARITY_EN
    q0.push_back(int'(v_par[idx]));
    q1.push_back(int'(v_par[idx]));
`endif
    q0.push_back(DONE_TOK);
    q1.push_back(DONE_TOK);
  endtask

  // Monitor: every cycle the head of each queue dictates what the outputs must show.
  always @(negedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (qsz(ch) > 0 && qfront(ch) == DONE_TOK) begin
          chk("done_pulse", ch, 32'(w_done[ch]), 32'd1);
          chk("busy_in_done_cycle", ch, 32'(w_busy[ch]), 32'd0);
          chk("ser_valid_in_done_cycle", ch, 32'(w_ser_valid[ch]), 32'd0);
          chk("load_ready_in_done_cycle", ch, 32'(w_load_ready[ch]), 32'd1);
          chk("ser_out_in_done_cycle", ch, 32'(w_ser_out[ch]), 32'd0);
          qpop(ch);
        end else if (qsz(ch) > 0) begin
          chk("ser_valid_active", ch, 32'(w_ser_valid[ch]), 32'd1);
          chk("busy_active", ch, 32'(w_busy[ch]), 32'd1);
          chk("load_ready_active", ch, 32'(w_load_ready[ch]), 32'd0);
          chk("done_active", ch, 32'(w_done[ch]), 32'd0);
          chk("ser_out_bit", ch, 32'(w_ser_out[ch]), 32'(qfront(ch)));
          if (shift_en) qpop(ch);
        end else begin
          chk("ser_valid_idle", ch, 32'(w_ser_valid[ch]), 32'd0);
          chk("busy_idle", ch, 32'(w_busy[ch]), 32'd0);
          chk("load_ready_idle", ch, 32'(w_load_ready[ch]), 32'd1);
          chk("done_idle", ch, 32'(w_done[ch]), 32'd0);
          chk("ser_out_idle", ch, 32'(w_ser_out[ch]), 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for acceptance, then consume its bits with an optional stall.
  task automatic send(input int idx, input int stall_bit, input int stall_len);
    int w;
    load_valid = 1'b1;
    load_data  = v_data[idx];
    w = 0;
    @(negedge clk);
    while (!(w_load_ready[0] && w_load_ready[1]) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("load_accept_timeout", 0, 32'd0, 32'd1);
    @(posedge clk);
    push_word(idx);
    #1;
    load_valid = 1'b0;
    shift_en   = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (k == stall_bit) begin
        shift_en = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
        shift_en = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    shift_en = 1'b0;
  endtask

  // Reset arrives while bit 4 of the word is on ser_out; the word must vanish without a done pulse.
  task automatic abort_word(input int idx);
    load_valid = 1'b1;
    load_data  = v_data[idx];
    @(posedge clk);
    push_word(idx);
    #1;
    load_valid = 1'b0;
    shift_en   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst      = 1'b1;
    shift_en = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk("abort_ser_valid", ch, 32'(w_ser_valid[ch]), 32'd0);
      chk("abort_busy", ch, 32'(w_busy[ch]), 32'd0);
      chk("abort_done", ch, 32'(w_done[ch]), 32'd0);
      chk("abort_load_ready", ch, 32'(w_load_ready[ch]), 32'd1);
      chk("abort_ser_out", ch, 32'(w_ser_out[ch]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    clk        = 1'b0;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    shift_en   = 1'b0;

    v_data[0] = 8'hA5; v_lsb[0] = 8'b10100101; v_msb[0] = 8'b10100101; v_par[0] = 1'b0;
    v_data[1] = 8'h80; v_lsb[1] = 8'b00000001; v_msb[1] = 8'b10000000; v_par[1] = 1'b1;
    v_data[2] = 8'h0F; v_lsb[2] = 8'b11110000; v_msb[2] = 8'b00001111; v_par[2] = 1'b0;
    v_data[3] = 8'h07; v_lsb[3] = 8'b11100000; v_msb[3] = 8'b00000111; v_par[3] = 1'b1;
    v_data[4] = 8'h03; v_lsb[4] = 8'b11000000; v_msb[4] = 8'b00000011; v_par[4] = 1'b0;
    v_data[5] = 8'hFF; v_lsb[5] = 8'b11111111; v_msb[5] = 8'b11111111; v_par[5] = 1'b0;
    v_data[6] = 8'h01; v_lsb[6] = 8'b10000000; v_msb[6] = 8'b00000001; v_par[6] = 1'b1;
    v_data[7] = 8'h3C; v_lsb[7] = 8'b00111100; v_msb[7] = 8'b00111100; v_par[7] = 1'b0;

    #2;
    rst = 1'b1;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      chk("reset_ser_out", ch, 32'(w_ser_out[ch]), 32'd0);
      chk("reset_ser_valid", ch, 32'(w_ser_valid[ch]), 32'd0);
      chk("reset_busy", ch, 32'(w_busy[ch]), 32'd0);
      chk("reset_done", ch, 32'(w_done[ch]), 32'd0);
      chk("reset_load_ready", ch, 32'(w_load_ready[ch]), 32'd1);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    shift_en = 1'b1;
    idle(2);
    shift_en = 1'b0;

    send(0, -1, 0);
    idle(2);
    send(1, -1, 0);
    send(2, 2, 3);
    send(3, -1, 0);
    send(4, -1, 0);
    idle(2);
    abort_word(5);
    idle(3);
    send(6, -1, 0);
    send(7, -1, 0);
    idle(3);

    chk("scoreboard_drained", 0, 32'(q0.size()), 32'd0);
    chk("scoreboard_drained", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
